// File: rtl/hub75_bcm_scan.sv
// HUB75 scan engine with binary-coded modulation. The next bit plane is shifted
// while the current one is displayed, and all panel timing runs off a tick prescaler.
module hub75_bcm_scan #(
  parameter int COLS    = 64,
  parameter int ROWS    = 32,
  parameter int BPC     = 4,
  parameter int CLK_DIV = 27,
  parameter int BASE_ON = 8,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int AW = CW + RW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic [AW-1:0]   fb_addr,
  input  logic [6*BPC-1:0] fb_data,
  output logic            H75_R1,
  output logic            H75_G1,
  output logic            H75_B1,
  output logic            H75_R2,
  output logic            H75_G2,
  output logic            H75_B2,
  output logic            H75_Clk,
  output logic            H75_Lat,
  output logic            H75_OE,
  output logic            H75_A,
  output logic            H75_B,
  output logic            H75_C,
  output logic            H75_D,
  output logic            H75_E,
  output logic            frame_done
);

  localparam int TW = $clog2(BASE_ON << (BPC-1)) + 1;
  localparam int SW = $clog2(2*COLS+1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_BLANK, S_LATCH, S_UNLATCH, S_UNBLANK
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_div;
  logic [SW-1:0]     r_step, w_step_n;
  logic [RW-1:0]     r_row, w_row_n, w_row_adv;
  logic [PW-1:0]     r_plane, w_plane_n, w_plane_adv;
  logic [TW-1:0]     r_timer, w_timer_n;
  logic              r_oe, w_oe_n;
  logic              r_lat, w_lat_n;
  logic              r_clk, w_clk_n;
  logic [5:0]        r_rgb, w_rgb_n;
  logic [AW-1:0]     r_fb_addr, w_addr_n;
  logic [RW-1:0]     r_row_addr, w_row_addr_n;
  logic              r_done, w_done_n;

  logic              w_tick;
  logic [5:0][BPC-1:0] w_field;
  logic [5:0]        w_bits;
  logic [CW-1:0]     w_col;
  logic              w_last_step, w_plane_last, w_wrap;
  logic [4:0]        w_rowpad;

  assign w_tick       = (r_div == DW'(CLK_DIV-1));
  assign w_field      = fb_data;
  assign w_col        = r_step[CW:1];
  assign w_last_step  = (r_step == SW'(2*COLS));
  assign w_plane_last = (r_plane == PW'(BPC-1));
  assign w_wrap       = w_plane_last && (r_row == RW'(ROWS-1));
  assign w_row_adv    = w_plane_last ? r_row + RW'(1) : r_row;
  assign w_plane_adv  = w_plane_last ? '0 : r_plane + PW'(1);

  for (genvar k = 0; k < 6; k++) begin : g_bit
    assign w_bits[k] = w_field[k][r_plane];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else if (w_tick) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = enable ? S_SHIFT : S_IDLE;
      S_SHIFT:   w_state_nxt = w_last_step ? S_WAIT : S_SHIFT;
      // Leave on the tick the display timer expires so no idle tick is spent here.
      S_WAIT:    w_state_nxt = (r_timer <= TW'(1)) ? S_BLANK : S_WAIT;
      S_BLANK:   w_state_nxt = S_LATCH;
      S_LATCH:   w_state_nxt = S_UNLATCH;
      S_UNLATCH: w_state_nxt = S_UNBLANK;
      S_UNBLANK: w_state_nxt = (w_wrap && !enable) ? S_IDLE : S_SHIFT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_oe_n       = r_oe;
    w_lat_n      = r_lat;
    w_clk_n      = r_clk;
    w_rgb_n      = r_rgb;
    w_addr_n     = r_fb_addr;
    w_row_addr_n = r_row_addr;
    w_step_n     = r_step;
    w_row_n      = r_row;
    w_plane_n    = r_plane;
    w_timer_n    = r_timer;
    w_done_n     = 1'b0;
    if (r_timer != '0) begin
      w_timer_n = r_timer - TW'(1);
      if (r_timer == TW'(1)) w_oe_n = 1'b1;
    end
    case (r_state)
      S_IDLE: if (enable) begin
        w_addr_n = {r_row, CW'(0)};
        w_step_n = '0;
      end
      S_SHIFT: begin
        if (!r_step[0]) begin
          w_clk_n = 1'b0;
          if (!w_last_step) begin
            w_rgb_n  = w_bits;
            w_addr_n = {r_row, w_col + CW'(1)};
          end
        end else begin
          w_clk_n = 1'b1;
        end
        w_step_n = w_last_step ? '0 : r_step + SW'(1);
      end
      S_BLANK:   w_oe_n = 1'b1;
      S_LATCH: begin
        w_lat_n      = 1'b1;
        w_row_addr_n = r_row;
        w_done_n     = w_wrap;
      end
      S_UNLATCH: w_lat_n = 1'b0;
      S_UNBLANK: begin
        w_oe_n    = 1'b0;
        w_timer_n = TW'(BASE_ON) << r_plane;
        w_row_n   = w_row_adv;
        w_plane_n = w_plane_adv;
        w_step_n  = '0;
        if (w_state_nxt == S_SHIFT) w_addr_n = {w_row_adv, CW'(0)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_step     <= '0;
      r_row      <= '0;
      r_plane    <= '0;
      r_timer    <= '0;
      r_oe       <= 1'b1;
      r_lat      <= 1'b0;
      r_clk      <= 1'b0;
      r_rgb      <= '0;
      r_fb_addr  <= '0;
      r_row_addr <= '0;
      r_done     <= 1'b0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + DW'(1);
      r_done <= w_tick & w_done_n;
      if (w_tick) begin
        r_step     <= w_step_n;
        r_row      <= w_row_n;
        r_plane    <= w_plane_n;
        r_timer    <= w_timer_n;
        r_oe       <= w_oe_n;
        r_lat      <= w_lat_n;
        r_clk      <= w_clk_n;
        r_rgb      <= w_rgb_n;
        r_fb_addr  <= w_addr_n;
        r_row_addr <= w_row_addr_n;
      end
    end
  end

  assign w_rowpad   = 5'(r_row_addr);
  assign fb_addr    = r_fb_addr;
  assign H75_R1     = r_rgb[0];
  assign H75_G1     = r_rgb[1];
  assign H75_B1     = r_rgb[2];
  assign H75_R2     = r_rgb[3];
  assign H75_G2     = r_rgb[4];
  assign H75_B2     = r_rgb[5];
  assign H75_Clk    = r_clk;
  assign H75_Lat    = r_lat;
  assign H75_OE     = r_oe;
  assign H75_A      = w_rowpad[0];
  assign H75_B      = w_rowpad[1];
  assign H75_C      = w_rowpad[2];
  assign H75_D      = w_rowpad[3];
  assign H75_E      = w_rowpad[4];
  assign frame_done = r_done;

endmodule
